nand_pattern_checker: RTL and testbench

// - Drives the two inputs of a 2-input CMOS NAND cell and checks its output, in place of a hand-written clock stimulus.
// - Steps exhaustively through {B,A} = 00,01,10,11 with A as LSB, holding each vector HOLD_CYCLES clocks.
// - Samples the DUT output after a settle window, compares it to ~(A&B), then reports pass/fail, error count and first failing vector.
// - Sits in the cell-characterisation bench around any 2-input NAND netlist.

---
 rtl/nand_chk_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/nand_pattern_checker.sv | 134 +++++++++++++
 tb/tb_nand_pattern_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_chk_pkg.sv
// Shared types and helpers for the 2-input NAND pattern checker.
// The expected response is derived from the applied {B,A} vector.
package nand_chk_pkg;

  localparam int unsigned VEC_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic nand_expect(input logic [VEC_W-1:0] vec);
    return ~(vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/nand_pattern_checker.sv
// Sweeps {B,A} through 00..11 on a NAND cell, compares the synchronised output
// against ~(A&B) after a settle window and reports pass, error count and first failure.
module nand_pattern_checker
  import nand_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_PASSES    = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int unsigned SWEEP_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  SETTLE_AT  = HOLD_W'(SETTLE_CYCLES);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(NUM_PASSES - 1);

  state_e             r_state;
  logic [VEC_W-1:0]   r_vec;
  logic [HOLD_W-1:0]  r_hold;
  logic [SWEEP_W-1:0] r_sweep;
  logic [ERR_W-1:0]   r_err;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_ff_valid;
  logic [VEC_W-1:0]   r_ff_vec;

  logic               w_dout_s;
  logic               w_mismatch;
  logic               w_step;
  logic               w_end;
  logic [ERR_W-1:0]   w_err_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (w_dout_s)
  );

  always_comb begin
    w_mismatch = (r_state == RUN) && (r_hold == SETTLE_AT) &&
                 (w_dout_s != nand_expect(r_vec));
    w_step     = (r_state == RUN) && (r_hold == HOLD_LAST);
    w_end      = w_step && (r_vec == 2'b11) && (r_sweep == SWEEP_LAST);
    w_err_next = r_err;
    if (w_mismatch && (r_err != '1)) begin
      w_err_next = r_err + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_hold     <= '0;
      r_sweep    <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_vec      <= '0;
            r_hold     <= '0;
            r_sweep    <= '0;
            r_err      <= '0;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
          end
        end
        RUN: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_vec   <= r_vec;
          end
          r_hold <= w_step ? '0 : r_hold + 1'b1;
          if (w_end) begin
            // pass uses the next error count so a compare on the final hold cycle is included
            r_state <= DONE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else if (w_step) begin
            r_vec <= r_vec + 1'b1;
            if (r_vec == 2'b11) begin
              r_sweep <= r_sweep + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dut_a            = r_vec[0];
  assign dut_b            = r_vec[1];
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_nand_pattern_checker.sv
// Directed bench: a behavioural NAND model (good, stuck-at, delayed) around the checker,
// plus two NUM_PASSES=2 instances with a stuck-at-0 output.
module tb_nand_pattern_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_p2 = 1'b0;

  always #5 clk = ~clk;

  // default instance
  logic       dut_a, dut_b, dut_out, busy, done, pass, ffv;
  logic [7:0] err;
  logic [1:0] ffvec;

  // NUM_PASSES=2 instances, outputs stuck at 0
  logic       p2_a, p2_b, p2_busy, p2_done, p2_pass, p2_ffv;
  logic [7:0] p2_err;
  logic [1:0] p2_ffvec;
  logic       w2_a, w2_b, w2_busy, w2_done, w2_pass, w2_ffv;
  logic [1:0] w2_err;
  logic [1:0] w2_ffvec;

  int checks = 0;
  int errors = 0;

  // model: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 good delayed by dly_n clocks
  int         mode = 0;
  int         dly_n = 0;
  logic [3:0] dly = 4'b1111;

  always @(posedge clk) dly <= {dly[2:0], ~(dut_a & dut_b)};

  always_comb begin
    dut_out = ~(dut_a & dut_b);
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = 1'b0;
      3:       dut_out = (dly_n == 0) ? ~(dut_a & dut_b) : dly[dly_n-1];
      default: dut_out = ~(dut_a & dut_b);
    endcase
  end

  nand_pattern_checker u_def (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_out          (dut_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err),
    .first_fail_valid (ffv),
    .first_fail_vec   (ffvec)
  );

  nand_pattern_checker #(.NUM_PASSES(2)) u_p2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_p2),
    .dut_a            (p2_a),
    .dut_b            (p2_b),
    .dut_out          (1'b0),
    .busy             (p2_busy),
    .done             (p2_done),
    .pass             (p2_pass),
    .err_count        (p2_err),
    .first_fail_valid (p2_ffv),
    .first_fail_vec   (p2_ffvec)
  );

  nand_pattern_checker #(.NUM_PASSES(2), .ERR_W(2)) u_w2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_p2),
    .dut_a            (w2_a),
    .dut_b            (w2_b),
    .dut_out          (1'b0),
    .busy             (w2_busy),
    .done             (w2_done),
    .pass             (w2_pass),
    .err_count        (w2_err),
    .first_fail_valid (w2_ffv),
    .first_fail_vec   (w2_ffvec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  logic [1:0] v9, v17, v25;

  // cyc counts posedges from (and including) the one that samples start until done is seen
  task automatic run_def(input bit poke_start, output int cyc);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke_start && cyc == 6);
      if (cyc == 9)  v9  = {dut_b, dut_a};
      if (cyc == 17) v17 = {dut_b, dut_a};
      if (cyc == 25) v25 = {dut_b, dut_a};
    end
    start = 1'b0;
  endtask

  int cyc;

  initial begin
    // reset state
    #12;
    check("rst_outputs", {busy, done, pass, dut_b, dut_a, ffv, ffvec, err}, 32'h0);
    check("rst_p2_outputs", {p2_busy, p2_done, p2_pass, p2_b, p2_a, p2_ffv, p2_err}, 32'h0);
    check("rst_w2_err", {w2_busy, w2_done, w2_err}, 32'h0);
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(4);
    check("idle_busy", busy, 1'b0);

    // good NAND, defaults
    mode = 0;
    run_def(1'b0, cyc);
    check("good_latency", cyc, 33);
    check("good_vec_01", v9, 2'b01);
    check("good_vec_10", v17, 2'b10);
    check("good_vec_11", v25, 2'b11);
    check("good_pass", pass, 1'b1);
    check("good_err", err, 8'd0);
    check("good_ffv", ffv, 1'b0);
    check("good_done_busy_dut", {busy, dut_b, dut_a}, 3'b000);
    idle_cycles(1);
    check("good_done_pulse", done, 1'b0);
    check("good_pass_hold", pass, 1'b1);
    idle_cycles(5);

    // output stuck-at-1: only 11 expects 0
    mode = 1;
    run_def(1'b0, cyc);
    check("sa1_latency", cyc, 33);
    check("sa1_err", err, 8'd1);
    check("sa1_ffvec", {ffv, ffvec}, 3'b111);
    check("sa1_pass", pass, 1'b0);
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_ignored", {busy, done}, 2'b00);
    idle_cycles(3);
    check("done_start_still_idle", busy, 1'b0);
    check("sa1_result_hold", {ffv, ffvec, err}, {3'b111, 8'd1});
    idle_cycles(5);

    // 2-clock delay is within tolerance; also poke start mid-run
    mode = 3;
    dly_n = 2;
    run_def(1'b1, cyc);
    check("dly2_latency_start_ignored", cyc, 33);
    check("dly2_pass", pass, 1'b1);
    check("dly2_err", err, 8'd0);
    idle_cycles(5);

    // 3-clock delay: compare sees the previous vector's response; only 11 differs
    dly_n = 3;
    run_def(1'b0, cyc);
    check("dly3_err", err, 8'd1);
    check("dly3_ffvec", {ffv, ffvec}, 3'b111);
    check("dly3_pass", pass, 1'b0);
    idle_cycles(5);

    // reset while vec=10, stuck-at-0 so errors are already counted
    mode = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while ({dut_b, dut_a} != 2'b10 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mid_reached_10", {busy, dut_b, dut_a}, 3'b110);
    check("mid_err_before_rst", {ffv, ffvec, err}, {3'b100, 8'd2});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {busy, done, pass, dut_b, dut_a, ffv, ffvec, err}, 32'h0);
    idle_cycles(2);
    check("mid_rst_no_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    mode = 0;
    run_def(1'b0, cyc);
    check("restart_latency", cyc, 33);
    check("restart_pass", {pass, ffv, err}, {1'b1, 1'b0, 8'd0});
    idle_cycles(3);

    // NUM_PASSES=2, stuck-at-0: 00,01,10 fail in each sweep
    start_p2 = 1'b1;
    @(posedge clk);
    #1;
    start_p2 = 1'b0;
    cyc = 1;
    while (!p2_done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("p2_latency", cyc, 65);
    check("p2_err", p2_err, 8'd6);
    check("p2_ffvec", {p2_ffv, p2_ffvec}, 3'b100);
    check("p2_pass", p2_pass, 1'b0);
    check("w2_done_aligned", w2_done, 1'b1);
    check("w2_err_saturated", w2_err, 2'b11);
    check("w2_pass", {w2_pass, w2_ffv, w2_ffvec}, 4'b0100);
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
